// File: rtl/sfifo_pkg.sv
// Shared helpers for the sfifo_level FIFO family: level-counter width and
// elaboration-time legality checks for the almost-full/almost-empty thresholds.
// No logic, no latency, no flow control; constants and constant functions only.
package sfifo_pkg;

  // Level counter must hold 0..SIZE inclusive, hence one bit wider than the pointers.
  function automatic int level_bits(input int abits);
    return abits + 1;
  endfunction

  // afull_o must be low after reset/clear, so AFULL may not be 0.
  function automatic bit afull_legal(input int afull, input int abits);
    return (afull >= 1) && (afull <= (1 << abits));
  endfunction

  // aempty_o must fall at some level below SIZE to be meaningful.
  function automatic bit aempty_legal(input int aempty, input int abits);
    return (aempty >= 0) && (aempty <= (1 << abits) - 1);
  endfunction

endpackage

// File: rtl/sfifo_ram.sv
// Storage for sfifo_level: WIDTH x 2**ABITS, one write port, one read port.
// Latency: 1 cycle registered read (default) or 0 cycles asynchronous read (SFIFO_LEVEL_FWFT_EN).
// No backpressure; the caller only issues legal, non-colliding accesses.
//
// Ports: clock_i; rst_i clears the read-data register only (array is never reset);
//        wen_i/waddr_i/wdata_i write port; ren_i/raddr_i/rdata_o read port.
// Macro: SFIFO_LEVEL_FWFT_EN selects asynchronous read.
module sfifo_ram
  import sfifo_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int ABITS = 4
) (
  input  logic             clock_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             ren_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int SIZE = 2 ** ABITS;

  logic [WIDTH-1:0] mem_q [SIZE];

  always_ff @(posedge clock_i) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

`ifdef SFIFO_LEVEL_FWFT_EN
  // Head word is presented combinationally; no output register to clear.
  logic unused_rd_ctrl;
  assign unused_rd_ctrl = rst_i ^ ren_i;
  assign rdata_o        = mem_q[raddr_i];
`else
  // Output register with synchronous clear maps onto a block-RAM output latch.
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (ren_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sfifo_level.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds, sticky error flags, flush.
// Latency: status flags 1 cycle after the operation; read data 1 cycle (default) or 0 cycles (FWFT).
// Backpressure: writes when full and reads when empty are dropped and latch overflow_o/underflow_o.
//
// Ports: clock_i, reset_i (sync, active high), clear_i (sync flush);
//        write_i/data_i write side; read_i/data_o/valid_o read side;
//        empty_o, full_o, aempty_o, afull_o, level_o status; overflow_o, underflow_o sticky errors.
// Macro: SFIFO_LEVEL_FWFT_EN enables first-word-fall-through mode.
module sfifo_level
  import sfifo_pkg::*;
#(
  parameter int WIDTH  = 18,
  parameter int ABITS  = 4,
  parameter int AFULL  = 12,
  parameter int AEMPTY = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             write_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             read_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             aempty_o,
  output logic             afull_o,
  output logic [ABITS:0]   level_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int SIZE = 2 ** ABITS;
  localparam int LW   = level_bits(ABITS);

  if (!afull_legal(AFULL, ABITS)) begin : g_bad_afull
    $error("sfifo_level: AFULL=%0d outside 1..%0d", AFULL, SIZE);
  end
  if (!aempty_legal(AEMPTY, ABITS)) begin : g_bad_aempty
    $error("sfifo_level: AEMPTY=%0d outside 0..%0d", AEMPTY, SIZE - 1);
  end

  logic [ABITS-1:0] wptr_q, wptr_d;
  logic [ABITS-1:0] rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             aempty_q, aempty_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic wr_acc, rd_acc;
  logic ram_wen, ram_ren;

  // Acceptance uses registered flags only, so there is no input-to-flag combinational path.
  assign wr_acc  = write_i && !full_q;
  assign rd_acc  = read_i && !empty_q;
  assign ram_wen = wr_acc && !clear_i;
  assign ram_ren = rd_acc && !clear_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + ABITS'(1);
      if (rd_acc) rptr_d = rptr_q + ABITS'(1);
      // A write on full is dropped even if a read frees a slot in the same cycle.
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      ovf_d = ovf_q | (write_i & full_q);
      udf_d = udf_q | (read_i & empty_q);
    end

    empty_d  = (level_d == '0);
    full_d   = (level_d == LW'(SIZE));
    aempty_d = (level_d <= LW'(AEMPTY));
    afull_d  = (level_d >= LW'(AFULL));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  sfifo_ram #(
    .WIDTH (WIDTH),
    .ABITS (ABITS)
  ) u_ram (
    .clock_i (clock_i),
    .rst_i   (reset_i || clear_i),
    .wen_i   (ram_wen),
    .waddr_i (wptr_q),
    .wdata_i (data_i),
    .ren_i   (ram_ren),
    .raddr_i (rptr_q),
    .rdata_o (data_o)
  );

`ifdef SFIFO_LEVEL_FWFT_EN
  assign valid_o = !empty_q;
`else
  // One-cycle pulse aligned with the registered RAM output.
  logic valid_q, valid_d;

  assign valid_d = ram_ren;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
`endif

  assign empty_o     = empty_q;
  assign full_o      = full_q;
  assign aempty_o    = aempty_q;
  assign afull_o     = afull_q;
  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: tb/tb_sfifo_level.sv
// Testbench for sfifo_level with default parameters (18 x 16, AFULL 12, AEMPTY 2).
// Reference FIFO model feeds an expected-read queue; a monitor pops it on each DUT read output.
// Honors SFIFO_LEVEL_FWFT_EN for same-cycle read data.
module tb_sfifo_level;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        write_i = 1'b0;
  logic [17:0] data_i = '0;
  logic        read_i = 1'b0;
  logic [17:0] data_o;
  logic        valid_o, empty_o, full_o, aempty_o, afull_o;
  logic [4:0]  level_o;
  logic        overflow_o, underflow_o;

  int n_vec = 0;
  int n_bad = 0;

  logic [17:0] mq[$];     // model contents
  logic [17:0] exp_q[$];  // words the DUT must still present, in order
  bit          m_ovf, m_udf;

  always #5 clk = ~clk;

  sfifo_level #(
    .WIDTH (18),
    .ABITS (4),
    .AFULL (12),
    .AEMPTY(2)
  ) dut (
    .clock_i    (clk),
    .reset_i    (reset_i),
    .clear_i    (clear_i),
    .write_i    (write_i),
    .data_i     (data_i),
    .read_i     (read_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .aempty_o   (aempty_o),
    .afull_o    (afull_o),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .underflow_o(underflow_o)
  );

  // Scoreboard: compare every read word the DUT presents against the model order.
  always @(negedge clk) begin
    logic [17:0] e;
    bit          take;
`ifdef SFIFO_LEVEL_FWFT_EN
    take = read_i && (valid_o === 1'b1);
`else
    take = (valid_o === 1'b1);
`endif
    if (take) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rd_unexpected data_o=%h with no word expected", data_o);
      end else begin
        e = exp_q.pop_front();
        if (data_o !== e) begin
          n_bad++;
          $display("FAIL rd_data got %h want %h", data_o, e);
        end
      end
    end
  end

  // One clock of stimulus; updates the reference model with the same rules as the FIFO.
  task automatic step(input bit wr, input logic [17:0] wd, input bit rd,
                      input bit clr, input bit rst);
    bit m_full, m_empty;
    write_i = wr;
    data_i  = wd;
    read_i  = rd;
    clear_i = clr;
    reset_i = rst;
    if (rst || clr) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      m_full  = (mq.size() == 16);
      m_empty = (mq.size() == 0);
      if (wr && m_full) m_ovf = 1;
      if (rd && m_empty) m_udf = 1;
      if (rd && !m_empty) exp_q.push_back(mq.pop_front());
      if (wr && !m_full) mq.push_back(wd);
    end
    @(posedge clk);
    #1;
    write_i = 1'b0;
    read_i  = 1'b0;
    clear_i = 1'b0;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    n_vec++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", level_o); end
    n_vec++; if ({empty_o, full_o, aempty_o, afull_o} !== 4'b1010) begin n_bad++; $display("FAIL reset_flags got %b want 1010", {empty_o, full_o, aempty_o, afull_o}); end
    n_vec++; if ({overflow_o, underflow_o, valid_o} !== 3'b000) begin n_bad++; $display("FAIL reset_err_valid got %b want 000", {overflow_o, underflow_o, valid_o}); end
`ifndef SFIFO_LEVEL_FWFT_EN
    n_vec++; if (data_o !== 18'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", data_o); end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1, 18'(i), 0, 0, 0);
      n_vec++; if (level_o !== 5'(i + 1)) begin n_bad++; $display("FAIL fill_level got %0d want %0d", level_o, i + 1); end
      n_vec++; if (afull_o !== (i + 1 >= 12)) begin n_bad++; $display("FAIL fill_afull at %0d got %b", i + 1, afull_o); end
      n_vec++; if (full_o !== (i + 1 == 16)) begin n_bad++; $display("FAIL fill_full at %0d got %b", i + 1, full_o); end
      n_vec++; if (aempty_o !== (i + 1 <= 2)) begin n_bad++; $display("FAIL fill_aempty at %0d got %b", i + 1, aempty_o); end
    end
    step(1, 18'h3ABCD, 0, 0, 0);
    n_vec++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", overflow_o); end
    n_vec++; if (level_o !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d want 16", level_o); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, 0, 0);
      n_vec++; if (level_o !== 5'(15 - i)) begin n_bad++; $display("FAIL drain_level got %0d want %0d", level_o, 15 - i); end
      n_vec++; if (aempty_o !== (15 - i <= 2)) begin n_bad++; $display("FAIL drain_aempty at %0d got %b", 15 - i, aempty_o); end
`ifndef SFIFO_LEVEL_FWFT_EN
      n_vec++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL drain_valid got %b want 1", valid_o); end
`endif
    end
    step(0, '0, 1, 0, 0);
    n_vec++; if ({empty_o, underflow_o, overflow_o} !== 3'b111) begin n_bad++; $display("FAIL udf_flags got %b want 111", {empty_o, underflow_o, overflow_o}); end
    n_vec++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL udf_level got %0d want 0", level_o); end
    n_vec++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL udf_valid got %b want 0", valid_o); end
`ifndef SFIFO_LEVEL_FWFT_EN
    n_vec++; if (data_o !== 18'd15) begin n_bad++; $display("FAIL data_hold got %h want 00f", data_o); end
`endif
  endtask

  task automatic test_back_to_back();
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(1, 18'(50 + i), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      step(1, 18'(100 + i), 1, 0, 0);
      n_vec++; if (level_o !== 5'd8) begin n_bad++; $display("FAIL b2b_level cycle %0d got %0d want 8", i, level_o); end
    end
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL b2b_pending got %0d words want 0", exp_q.size()); end
    n_vec++; if (empty_o !== 1'b1) begin n_bad++; $display("FAIL b2b_empty got %b want 1", empty_o); end
  endtask

  task automatic test_full_rw();
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 18'(300 + i), 0, 0, 0);
    step(1, 18'h3FFFF, 1, 0, 0);
    n_vec++; if (overflow_o !== 1'b1) begin n_bad++; $display("FAIL fullrw_ovf got %b want 1", overflow_o); end
    n_vec++; if (level_o !== 5'd15) begin n_bad++; $display("FAIL fullrw_level got %0d want 15", level_o); end
    n_vec++; if (full_o !== 1'b0) begin n_bad++; $display("FAIL fullrw_full got %b want 0", full_o); end
    for (int i = 0; i < 15; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fullrw_pending got %0d words want 0", exp_q.size()); end
  endtask

  task automatic test_clear();
    step(0, '0, 0, 1, 0);
    step(0, '0, 1, 0, 0);
    n_vec++; if (underflow_o !== 1'b1) begin n_bad++; $display("FAIL clr_pre_udf got %b want 1", underflow_o); end
    for (int i = 0; i < 5; i++) step(1, 18'(400 + i), 0, 0, 0);
    step(1, 18'h111, 0, 1, 0);
    n_vec++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL clr_level got %0d want 0", level_o); end
    n_vec++; if ({empty_o, aempty_o, full_o, afull_o, overflow_o, underflow_o, valid_o} !== 7'b1100000) begin
      n_bad++; $display("FAIL clr_flags got %b want 1100000", {empty_o, aempty_o, full_o, afull_o, overflow_o, underflow_o, valid_o});
    end
`ifndef SFIFO_LEVEL_FWFT_EN
    n_vec++; if (data_o !== 18'h0) begin n_bad++; $display("FAIL clr_data got %h want 0", data_o); end
`endif
    step(1, 18'h2A, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL clr_pending got %0d words want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 18'(500 + i), 0, 0, 0);
    n_vec++; if (level_o !== 5'd9) begin n_bad++; $display("FAIL rstmid_pre_level got %0d want 9", level_o); end
    step(1, 18'h555, 0, 0, 1);
    n_vec++; if (level_o !== 5'd0) begin n_bad++; $display("FAIL rstmid_level got %0d want 0", level_o); end
    n_vec++; if ({empty_o, aempty_o, full_o, afull_o, overflow_o, underflow_o, valid_o} !== 7'b1100000) begin
      n_bad++; $display("FAIL rstmid_flags got %b want 1100000", {empty_o, aempty_o, full_o, afull_o, overflow_o, underflow_o, valid_o});
    end
    step(1, 18'h77, 0, 0, 0);
    n_vec++; if ({level_o, empty_o} !== {5'd1, 1'b0}) begin n_bad++; $display("FAIL rstmid_resume got %0d/%b want 1/0", level_o, empty_o); end
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    n_vec++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rstmid_pending got %0d words want 0", exp_q.size()); end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_full_rw();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
